// File: rtl/fft16_pkg.sv
// Shared constants, FSM state type and the bin-index digit reversal for the
// 16-point streaming FFT sequencer.
package fft16_pkg;
    localparam int N_PT   = 16;
    localparam int LANE_W = 32;
    localparam int BUS_W  = N_PT * LANE_W;

    typedef enum logic [1:0] {LOAD, WAIT, UNLOAD} state_e;

    // Radix-4 digit swap: k = {d1,d0} -> {d0,d1}
    function automatic logic [3:0] digit_rev(input logic [3:0] k);
        return {k[1:0], k[3:2]};
    endfunction
endpackage

// File: rtl/fft16_stream_ctrl_if.sv
// Bundle of the sample stream, datapath lane buses and status of the FFT
// sequencer. slave = controller side, master = source/datapath/sink side.
interface fft16_stream_ctrl_if;
    import fft16_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [LANE_W-1:0] s_re;
    logic [LANE_W-1:0] s_im;
    logic              s_last;
    logic [BUS_W-1:0]  fft_r_in;
    logic [BUS_W-1:0]  fft_i_in;
    logic [BUS_W-1:0]  fft_r_out;
    logic [BUS_W-1:0]  fft_i_out;
    logic              m_valid;
    logic              m_ready;
    logic [LANE_W-1:0] m_re;
    logic [LANE_W-1:0] m_im;
    logic [3:0]        m_idx;
    logic              m_last;
    logic              busy;
    logic              err_frame;

    modport slave (
        input  s_valid, s_re, s_im, s_last, fft_r_out, fft_i_out, m_ready,
        output s_ready, fft_r_in, fft_i_in, m_valid, m_re, m_im, m_idx,
               m_last, busy, err_frame
    );

    modport master (
        output s_valid, s_re, s_im, s_last, fft_r_out, fft_i_out, m_ready,
        input  s_ready, fft_r_in, fft_i_in, m_valid, m_re, m_im, m_idx,
               m_last, busy, err_frame
    );
endinterface

// File: rtl/fft16_lane_buf.sv
// 16-lane complex register bank: serial write or parallel load in, parallel
// bus and indexed lane out. Parallel load takes priority over serial write.
module fft16_lane_buf
    import fft16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [3:0]        wr_idx,
    input  logic [LANE_W-1:0] wr_re,
    input  logic [LANE_W-1:0] wr_im,
    input  logic              ld_en,
    input  logic [BUS_W-1:0]  ld_re,
    input  logic [BUS_W-1:0]  ld_im,
    input  logic [3:0]        rd_idx,
    output logic [LANE_W-1:0] rd_re,
    output logic [LANE_W-1:0] rd_im,
    output logic [BUS_W-1:0]  par_re,
    output logic [BUS_W-1:0]  par_im
);
    logic [N_PT-1:0][LANE_W-1:0] re_q;
    logic [N_PT-1:0][LANE_W-1:0] im_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            re_q <= '0;
            im_q <= '0;
        end else if (ld_en) begin
            re_q <= ld_re;
            im_q <= ld_im;
        end else if (wr_en) begin
            re_q[wr_idx] <= wr_re;
            im_q[wr_idx] <= wr_im;
        end
    end

    // Packed lane n sits at bits [32n+31:32n] of the flat bus
    assign par_re = re_q;
    assign par_im = im_q;
    assign rd_re  = re_q[rd_idx];
    assign rd_im  = im_q[rd_idx];
endmodule

// File: rtl/fft16_stream_ctrl.sv
// Serial-to-parallel frame loader, fixed-latency wait and parallel-to-serial
// result replay around the 16-point FFT datapath.
module fft16_stream_ctrl
    import fft16_pkg::*;
#(
    parameter int FFT_LAT       = 2,
    parameter bit OUT_DIGIT_REV = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    fft16_stream_ctrl_if.slave  io
);
    localparam int WW = $clog2(FFT_LAT + 2);

    state_e          state, state_nx;
    logic [3:0]      wr_cnt, wr_nx;
    logic [3:0]      rd_cnt, rd_nx;
    logic [WW-1:0]   wait_cnt, wait_nx;
    logic            err_q, err_nx;
    logic            wr_en, ld_en;
    logic [3:0]      rd_lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            wr_cnt   <= wr_nx;
            rd_cnt   <= rd_nx;
            wait_cnt <= wait_nx;
            err_q    <= err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        wr_nx      = wr_cnt;
        rd_nx      = rd_cnt;
        wait_nx    = wait_cnt;
        err_nx     = 1'b0;
        wr_en      = 1'b0;
        ld_en      = 1'b0;
        io.s_ready = 1'b0;
        io.m_valid = 1'b0;
        unique case (state)
            LOAD: begin
                io.s_ready = 1'b1;
                if (io.s_valid) begin
                    wr_en  = 1'b1;
                    wr_nx  = wr_cnt + 4'd1;
                    // s_last only flags framing errors; length is fixed at 16
                    err_nx = io.s_last != (wr_cnt == 4'd15);
                    if (wr_cnt == 4'd15) begin
                        state_nx = WAIT;
                        wait_nx  = '0;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == WW'(FFT_LAT)) begin
                    ld_en    = 1'b1;
                    rd_nx    = '0;
                    state_nx = UNLOAD;
                end else begin
                    wait_nx = wait_cnt + WW'(1);
                end
            end
            UNLOAD: begin
                io.m_valid = 1'b1;
                if (io.m_ready) begin
                    rd_nx = rd_cnt + 4'd1;
                    if (rd_cnt == 4'd15) state_nx = LOAD;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    assign rd_lane      = OUT_DIGIT_REV ? digit_rev(rd_cnt) : rd_cnt;
    assign io.m_idx     = rd_cnt;
    assign io.m_last    = (state == UNLOAD) && (rd_cnt == 4'd15);
    assign io.busy      = (state != LOAD);
    assign io.err_frame = err_q;

    fft16_lane_buf u_load_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_idx (wr_cnt),
        .wr_re  (io.s_re),
        .wr_im  (io.s_im),
        .ld_en  (1'b0),
        .ld_re  ('0),
        .ld_im  ('0),
        .rd_idx (4'd0),
        .rd_re  (),
        .rd_im  (),
        .par_re (io.fft_r_in),
        .par_im (io.fft_i_in)
    );

    fft16_lane_buf u_res_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (1'b0),
        .wr_idx (4'd0),
        .wr_re  ('0),
        .wr_im  ('0),
        .ld_en  (ld_en),
        .ld_re  (io.fft_r_out),
        .ld_im  (io.fft_i_out),
        .rd_idx (rd_lane),
        .rd_re  (io.m_re),
        .rd_im  (io.m_im),
        .par_re (),
        .par_im ()
    );
endmodule

// File: tb/tb_fft16_stream_ctrl.sv
// Randomized scoreboard bench: two controllers (natural and digit-reversed
// order) share one stimulus stream and are checked against a frame model.
module tb_fft16_stream_ctrl;
    import fft16_pkg::*;

    localparam int LAT = 2;

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_last, m_ready;
    logic [31:0] s_re, s_im;
    int          mr_pct = 100;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fft16_stream_ctrl_if i0 ();
    fft16_stream_ctrl_if i1 ();

    assign i0.s_valid = s_valid;  assign i1.s_valid = s_valid;
    assign i0.s_re    = s_re;     assign i1.s_re    = s_re;
    assign i0.s_im    = s_im;     assign i1.s_im    = s_im;
    assign i0.s_last  = s_last;   assign i1.s_last  = s_last;
    assign i0.m_ready = m_ready;  assign i1.m_ready = m_ready;

    fft16_stream_ctrl #(.FFT_LAT(LAT), .OUT_DIGIT_REV(1'b0)) u_dut0 (
        .clk (clk), .rst (rst), .io (i0.slave));
    fft16_stream_ctrl #(.FFT_LAT(LAT), .OUT_DIGIT_REV(1'b1)) u_dut1 (
        .clk (clk), .rst (rst), .io (i1.slave));

    // Datapath stand-in: LAT register stages, re + 1000, im - 1000 per lane
    function automatic logic [BUS_W-1:0] add_lanes(input logic [BUS_W-1:0] b, input int d);
        logic [BUS_W-1:0] r;
        for (int k = 0; k < N_PT; k++) r[32*k +: 32] = b[32*k +: 32] + 32'(d);
        return r;
    endfunction

    logic [BUS_W-1:0] pr0 [LAT], pi0 [LAT], pr1 [LAT], pi1 [LAT];
    always @(posedge clk) begin
        pr0[0] <= add_lanes(i0.fft_r_in, 1000);
        pi0[0] <= add_lanes(i0.fft_i_in, -1000);
        pr1[0] <= add_lanes(i1.fft_r_in, 1000);
        pi1[0] <= add_lanes(i1.fft_i_in, -1000);
        for (int s = 1; s < LAT; s++) begin
            pr0[s] <= pr0[s-1]; pi0[s] <= pi0[s-1];
            pr1[s] <= pr1[s-1]; pi1[s] <= pi1[s-1];
        end
    end
    assign i0.fft_r_out = pr0[LAT-1];
    assign i0.fft_i_out = pi0[LAT-1];
    assign i1.fft_r_out = pr1[LAT-1];
    assign i1.fft_i_out = pi1[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + monitor ----------------
    exp_t        q0[$], q1[$];
    logic [31:0] in_re [16], in_im [16];
    int          in_cnt = 0, out_cnt = 0, cyc = 0, out_start = 0;
    bit          model_ok = 0, just_reset = 0, exp_sready = 1, err_pend = 0;

    initial begin
        forever begin
            bit exp_mv;
            @(negedge clk);
            cyc++;
            exp_mv = !exp_sready && (cyc >= out_start);
            if (model_ok) begin
                chk("s_ready0", i0.s_ready, exp_sready);
                chk("s_ready1", i1.s_ready, exp_sready);
                chk("busy0", i0.busy, !exp_sready);
                chk("busy1", i1.busy, !exp_sready);
                chk("err_frame0", i0.err_frame, err_pend);
                chk("err_frame1", i1.err_frame, err_pend);
                chk("m_valid0", i0.m_valid, exp_mv);
                chk("m_valid1", i1.m_valid, exp_mv);
                if (exp_mv && q0.size() > 0 && q1.size() > 0) begin
                    chk("m_re0", i0.m_re, q0[0].re);
                    chk("m_im0", i0.m_im, q0[0].im);
                    chk("m_idx0", i0.m_idx, q0[0].idx);
                    chk("m_last0", i0.m_last, q0[0].last);
                    chk("m_re1", i1.m_re, q1[0].re);
                    chk("m_im1", i1.m_im, q1[0].im);
                    chk("m_idx1", i1.m_idx, q1[0].idx);
                    chk("m_last1", i1.m_last, q1[0].last);
                end else begin
                    chk("m_last_idle0", i0.m_last, 1'b0);
                    chk("m_last_idle1", i1.m_last, 1'b0);
                end
                if (just_reset) begin
                    chk("rst_fft_r_in", |i0.fft_r_in, 1'b0);
                    chk("rst_fft_i_in", |i0.fft_i_in, 1'b0);
                    chk("rst_m_idx", i0.m_idx, 4'd0);
                    chk("rst_m_re", i0.m_re, 32'd0);
                end
            end
            // Apply what the coming clock edge does
            if (rst) begin
                model_ok = 1; just_reset = 1; exp_sready = 1; err_pend = 0;
                in_cnt = 0; out_cnt = 0;
                q0.delete(); q1.delete();
            end else if (model_ok) begin
                just_reset = 0;
                err_pend   = 0;
                if (exp_mv && m_ready) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                    out_cnt++;
                    if (out_cnt == 16) begin
                        out_cnt = 0;
                        exp_sready = 1;
                    end
                end else if (exp_sready && s_valid) begin
                    in_re[in_cnt] = s_re;
                    in_im[in_cnt] = s_im;
                    err_pend = (s_last != (in_cnt == 15));
                    in_cnt++;
                    if (in_cnt == 16) begin
                        for (int k = 0; k < 16; k++) begin
                            int   lr;
                            exp_t e;
                            lr = (k % 4) * 4 + k / 4;
                            e.idx = 4'(k); e.last = (k == 15);
                            e.re = in_re[k] + 32'd1000;  e.im = in_im[k] - 32'd1000;
                            q0.push_back(e);
                            e.re = in_re[lr] + 32'd1000; e.im = in_im[lr] - 32'd1000;
                            q1.push_back(e);
                        end
                        in_cnt = 0;
                        exp_sready = 0;
                        out_start = cyc + LAT + 2;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            m_ready = ($urandom_range(0, 99) < mr_pct);
        end
    end

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    task automatic send_sample(input logic [31:0] re, input logic [31:0] im,
                               input logic last, input int gap_pct);
        bit hs;
        int tmo;
        while ($urandom_range(0, 99) < gap_pct) begin
            s_valid = 1'b0; s_re = $urandom; s_im = $urandom; s_last = $urandom;
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_re = re; s_im = im; s_last = last;
        tmo = 0;
        do begin
            @(negedge clk); hs = i0.s_ready;
            @(posedge clk); #1;
            tmo++;
            if (tmo > 300) begin
                n_chk++; n_fail++;
                $display("FAIL input_timeout: got no s_ready, expected acceptance");
                finish_run();
            end
        end while (!hs);
        s_valid = 1'b0;
    endtask

    // kind 0: re=n, im=-n; kind 1: random. bad: 1 = extra s_last on 9, 2 = no s_last
    task automatic send_frame(input int kind, input int gap_pct, input int bad);
        for (int n = 0; n < 16; n++) begin
            logic [31:0] re, im;
            logic        last;
            re = (kind == 0) ? 32'(n) : $urandom;
            im = (kind == 0) ? -32'(n) : $urandom;
            last = (n == 15);
            if (bad == 1) last = (n == 9) || (n == 15);
            if (bad == 2) last = 1'b0;
            send_sample(re, im, last, gap_pct);
        end
    endtask

    task automatic wait_idle();
        int tmo = 0;
        while (!(exp_sready && q0.size() == 0)) begin
            @(negedge clk);
            tmo++;
            if (tmo > 2000) begin
                n_chk++; n_fail++;
                $display("FAIL idle_timeout: got %0d outputs pending, expected 0", q0.size());
                finish_run();
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_re = '0; s_im = '0; s_last = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Ramp frame, no backpressure
        send_frame(0, 0, 0);
        wait_idle();

        // Three back-to-back random frames with gaps and sink stalls
        mr_pct = 60;
        repeat (3) send_frame(1, 30, 0);
        wait_idle();

        // Framing errors: early s_last, then missing s_last
        mr_pct = 100;
        send_frame(1, 0, 1);
        send_frame(1, 0, 2);
        wait_idle();

        // Reset after 7 loaded samples
        for (int n = 0; n < 7; n++) send_sample(32'(n + 50), 32'(n), 1'b0, 0);
        pulse_reset();

        // Reset while replaying output k=5
        send_frame(0, 0, 0);
        begin
            int tmo = 0;
            do begin
                @(negedge clk);
                tmo++;
            end while (!(i0.m_valid && i0.m_idx == 4'd5) && tmo < 200);
            chk("reach_k5", (i0.m_valid && i0.m_idx == 4'd5), 1'b1);
        end
        @(posedge clk); #1;
        pulse_reset();

        // Clean frame after reset
        send_frame(0, 0, 0);
        wait_idle();
        repeat (3) @(posedge clk);
        finish_run();
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fft16_stream_ctrl.md
Name: fft16_stream_ctrl

Overview:
- Streaming sequencer for the 16-point radix-4 parallel FFT datapath (512-bit real and imaginary lane buses, fixed pipeline latency).
- Collects 16 serial complex samples over a valid/ready input, presents them as one parallel frame, and waits out the datapath latency.
- Captures the 16 parallel results and replays them serially over a valid/ready output.
- Sits between the sample source (ROM / serial-to-parallel path) and downstream demodulation logic.

Parameters:
- FFT_LAT, 2, clock edges from a stable input bus to a valid output bus (input register plus stage-2 register).
- OUT_DIGIT_REV, 0, if 1, output sample k is read from lane {k[1:0],k[3:2]} instead of lane k.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  controller can accept a sample
- s_re  in  32  input sample real part, signed
- s_im  in  32  input sample imaginary part, signed
- s_last  in  1  source marks the 16th sample of a frame
- fft_r_in  out  512  to datapath; lane n = bits [32n+31:32n]
- fft_i_in  out  512  to datapath, same lane packing
- fft_r_out  in  512  from datapath
- fft_i_out  in  512  from datapath
- m_valid  out  1  output sample valid
- m_ready  in  1  sink accepts the output sample
- m_re  out  32  output sample real part
- m_im  out  32  output sample imaginary part
- m_idx  out  4  bin index k of the current output sample
- m_last  out  1  high with k=15
- busy  out  1  high whenever state != LOAD
- err_frame  out  1  one-cycle pulse on an s_last mismatch

Behaviour:
- Reset (rst=1 at posedge): state=LOAD, counters=0, load and result buffers=0.
  - Outputs: s_ready=1, m_valid=0, m_idx=0, m_last=0, busy=0, err_frame=0, fft buses=0.
  - Reset mid-frame discards all partial input and output.
- LOAD: s_ready=1.
  - On s_valid&&s_ready, write sample into load-buffer lane wr_cnt, then wr_cnt++.
  - Check s_last against the sample position:
    - s_last=1 with wr_cnt!=15 -> err_frame pulse next cycle; sample still stored; counting continues.
    - s_last=0 with wr_cnt==15 -> same err_frame pulse.
  - Frame length is always exactly 16 accepted samples; s_last never truncates a frame.
  - The handshake at wr_cnt==15 moves to WAIT; wr_cnt wraps to 0.
- fft_r_in/fft_i_in are driven directly from the load-buffer registers.
  - They change only on LOAD handshakes, so they are stable for the whole of WAIT.
- WAIT: s_ready=0, m_valid=0, wait_cnt counts 0..FFT_LAT.
  - First WAIT cycle is T0, the first cycle in which the full frame is on the bus.
  - At the edge ending cycle T0+FFT_LAT, latch fft_r_out/fft_i_out into the result buffer and go to UNLOAD.
- UNLOAD: m_valid=1.
  - m_re/m_im come from result lane rd_cnt, or the digit-reversed lane when OUT_DIGIT_REV=1.
  - m_idx=rd_cnt; m_last=(rd_cnt==15).
  - On m_valid&&m_ready, rd_cnt++.
  - The handshake at rd_cnt==15 returns to LOAD with rd_cnt=0; s_ready=1 in the next cycle.
  - With m_ready=0, m_re, m_im, m_idx and m_last hold stable.
- Timing with no backpressure: last input handshake at edge E; first output valid in cycle E+FFT_LAT+2 (LAT=2: 4 cycles). Frame period = 16+FFT_LAT+1+16 cycles.
- Arithmetic: none; pure lane routing. Values pass bit-exact and signed.
- No overlap between frames: s_ready=0 throughout WAIT and UNLOAD.

Decomposition:
- Shared package fft16_pkg:
  - N_PT=16, LANE_W=32, BUS_W=512.
  - State enum {LOAD, WAIT, UNLOAD}.
  - Digit-reverse function for a 4-bit index.
- One natural sub-module: fft16_lane_buf, a 16x(2x32) register bank.
  - Ports: serial write at index, parallel 512-bit read, parallel 512-bit load, indexed serial read.
  - Instantiated twice: load buffer and result buffer.

Test Plan:
- Bench datapath stub: FFT_LAT-deep register pipeline; out lane k = in lane k + 1000, imag = in lane k - 1000.
- Reset then stream re=n, im=-n for n=0..15, m_ready=1 -> outputs k=0..15 give re=k+1000, im=-k-1000; first m_valid 4 cycles after the last input handshake; m_last only at k=15.
- Random s_valid gaps and random m_ready stalls over 3 back-to-back frames -> s_ready=0 during WAIT/UNLOAD; outputs held stable while stalled; no sample lost or duplicated.
- OUT_DIGIT_REV=1, inputs re=n -> output k carries re=1000+{k[1:0],k[3:2]} (k=1 -> 1004, k=4 -> 1001).
- s_last on sample 9 in one frame, missing on sample 15 in the next -> err_frame pulses once for each frame; both frames still complete with 16 outputs.
- Assert rst after 7 loaded samples, and again at output k=5 -> all outputs return to reset values next cycle; the following clean frame produces correct results from k=0.
